obi_rr_arbiter: RTL and testbench

- Parametrised successor of the single-fetch/single-LSU memory interface.
- Arbitrates NCH OBI requester channels (fetch, load/store, debug, ...) round-robin onto one shared OBI memory port.
- Adds byte enables, multiple outstanding transactions and in-order response routing through an ID FIFO.
- Sits between the CPU-side units and a single shared memory or bus.

---
 rtl/obi_rr_arbiter.sv | 166 ++++++++++++++++
 tb/tb_obi_rr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin arbiter, NCH OBI requesters onto one memory port.
// Ports: clk, rst (async, active-low); ch_* requester side; mem_* memory side;
//   outstanding_o = granted-but-unanswered count; err_o = sticky stray response.
module obi_rr_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 2,
  parameter int IDW     = $clog2(NCH),
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_req_i,
  input  logic [NCH*AW-1:0] ch_addr_i,
  input  logic [NCH-1:0]    ch_we_i,
  input  logic [NCH*DW/8-1:0] ch_be_i,
  input  logic [NCH*DW-1:0] ch_wdata_i,
  output logic [NCH-1:0]    ch_gnt_o,
  output logic [NCH-1:0]    ch_rvalid_o,
  output logic [DW-1:0]     ch_rdata_o,
  output logic              mem_req_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic              mem_we_o,
  output logic [DW/8-1:0]   mem_be_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic [CW-1:0]     outstanding_o,
  output logic              err_o
);

  localparam int BW = DW / 8;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [IDW-1:0] fifo_q [MAX_OUT];

  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] rr_sel;
  logic [IDW-1:0] rr_next;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] lock_idx_q;
  logic           lock_q;
  logic           err_q;

  logic full;
  logic req;
  logic hs;
  logic pop;
  logic spur;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // No push/pop bypass when full: a pending
  // response does not free a slot this cycle.
  assign full = (cnt_q == CW'(MAX_OUT));
  assign req  = rst & (|ch_req_i) & ~full;
  assign hs   = req & mem_gnt_i;
  assign pop  = rst & mem_rvalid_i & (cnt_q != '0);
  assign spur = mem_rvalid_i & (cnt_q == '0);

  // Descending scan so the smallest offset
  // from the pointer is the last to win.
  always_comb begin
    rr_sel = rr_q;
    idx    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = IDW'((int'(rr_q) + i) % NCH);
      if (ch_req_i[idx]) begin
        rr_sel = idx;
      end
    end
  end

  // A stalled request keeps its channel
  // until granted (OBI stability).
  assign sel = lock_q ? lock_idx_q : rr_sel;

  assign rr_next = (sel == IDW'(NCH - 1)) ?
                   '0 : sel + 1'b1;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (req) begin
      mem_addr_o  = ch_addr_i[sel*AW +: AW];
      mem_we_o    = ch_we_i[sel];
      mem_be_o    = ch_be_i[sel*BW +: BW];
      mem_wdata_o = ch_wdata_i[sel*DW +: DW];
    end
  end

  assign mem_req_o = req;

  assign ch_gnt_o = hs ?
    (NCH'(1) << sel) : '0;

  assign ch_rvalid_o = pop ?
    (NCH'(1) << fifo_q[head_q]) : '0;

  assign ch_rdata_o = (rst & mem_rvalid_i) ?
    mem_rdata_i : '0;

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      (hs & ~pop): cnt_d = cnt_q + CW'(1);
      (~hs & pop): cnt_d = cnt_q - CW'(1);
      default:     cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (hs) begin
        tail_q <= ptr_inc(tail_q);
        rr_q   <= rr_next;
        lock_q <= 1'b0;
      end else if (req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel;
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (spur) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (hs) begin
      fifo_q[tail_q] <= sel;
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed + random checks of obi_rr_arbiter
// against a queue-based reference model.
module tb_obi_rr_arbiter;
  localparam int NCH     = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int MAX_OUT = 2;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic [NCH-1:0]    we = '0;
  logic [NCH*BW-1:0] be = '0;
  logic [NCH*DW-1:0] wdata = '0;
  logic              gnt = 1'b0;
  logic              rvalid = 1'b0;
  logic [DW-1:0]     rdata = '0;

  logic [NCH-1:0] ch_gnt_o;
  logic [NCH-1:0] ch_rvalid_o;
  logic [DW-1:0]  ch_rdata_o;
  logic           mem_req_o;
  logic [AW-1:0]  mem_addr_o;
  logic           mem_we_o;
  logic [BW-1:0]  mem_be_o;
  logic [DW-1:0]  mem_wdata_o;
  logic [CW-1:0]  outstanding_o;
  logic           err_o;

  obi_rr_arbiter #(
    .NCH(NCH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ch_req_i(req),
    .ch_addr_i(addr),
    .ch_we_i(we),
    .ch_be_i(be),
    .ch_wdata_i(wdata),
    .ch_gnt_o(ch_gnt_o),
    .ch_rvalid_o(ch_rvalid_o),
    .ch_rdata_o(ch_rdata_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata),
    .outstanding_o(outstanding_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int q[$];
  int rr = 0;
  bit locked = 1'b0;
  int lock_ch = 0;
  bit err_m = 1'b0;

  logic           l_req;
  logic [NCH-1:0] l_gnt;
  logic [NCH-1:0] l_rv;
  logic [AW-1:0]  l_addr;
  logic           l_we;
  logic [BW-1:0]  l_be;
  logic [DW-1:0]  l_wdata;
  logic [DW-1:0]  l_rdata;
  logic [CW-1:0]  l_out;
  logic           l_err;

  logic [NCH-1:0] g[5];
  logic [NCH-1:0] r[5];

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: compare outputs with the model
  // mid-cycle, then advance the model at the edge.
  task automatic cyc();
    int sel;
    bit found;
    bit elig;
    logic [NCH-1:0] eg;
    logic [NCH-1:0] ev;
    #3;
    if (!rst) begin
      q.delete();
      rr = 0;
      locked = 1'b0;
      err_m = 1'b0;
    end
    elig = rst && (req != '0) && (q.size() < MAX_OUT);
    sel = 0;
    found = 1'b0;
    if (locked) begin
      sel = lock_ch;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!found && req[(rr + i) % NCH]) begin
          sel = (rr + i) % NCH;
          found = 1'b1;
        end
      end
    end
    eg = (elig && gnt) ? (NCH'(1) << sel) : '0;
    ev = (rst && rvalid && q.size() > 0) ?
         (NCH'(1) << q[0]) : '0;
    l_req = mem_req_o;
    l_gnt = ch_gnt_o;
    l_rv = ch_rvalid_o;
    l_addr = mem_addr_o;
    l_we = mem_we_o;
    l_be = mem_be_o;
    l_wdata = mem_wdata_o;
    l_rdata = ch_rdata_o;
    l_out = outstanding_o;
    l_err = err_o;
    check("mem_req", 64'(mem_req_o), 64'(elig));
    check("mem_addr", 64'(mem_addr_o),
          elig ? 64'(addr[sel*AW +: AW]) : 64'd0);
    check("mem_we", 64'(mem_we_o),
          elig ? 64'(we[sel]) : 64'd0);
    check("mem_be", 64'(mem_be_o),
          elig ? 64'(be[sel*BW +: BW]) : 64'd0);
    check("mem_wdata", 64'(mem_wdata_o),
          elig ? 64'(wdata[sel*DW +: DW]) : 64'd0);
    check("ch_gnt", 64'(ch_gnt_o), 64'(eg));
    check("ch_rvalid", 64'(ch_rvalid_o), 64'(ev));
    check("ch_rdata", 64'(ch_rdata_o),
          (rst && rvalid) ? 64'(rdata) : 64'd0);
    check("outstanding", 64'(outstanding_o),
          64'(q.size()));
    check("err", 64'(err_o), 64'(err_m));
    @(posedge clk);
    if (rst) begin
      if (rvalid) begin
        if (q.size() > 0) void'(q.pop_front());
        else err_m = 1'b1;
      end
      if (elig && gnt) begin
        q.push_back(sel);
        rr = (sel + 1) % NCH;
        locked = 1'b0;
      end else if (elig) begin
        locked = 1'b1;
        lock_ch = sel;
      end
    end
    #1;
  endtask

  task automatic idle();
    req = '0;
    gnt = 1'b0;
    rvalid = 1'b0;
    we = '0;
  endtask

  initial begin
    // reset with busy inputs
    rst = 1'b0;
    req = 2'b11;
    gnt = 1'b1;
    rvalid = 1'b1;
    rdata = 32'h1234;
    addr = {32'h2000, 32'h1000};
    cyc();
    check("rst_req", 64'(l_req), 64'd0);
    check("rst_gnt", 64'(l_gnt), 64'd0);
    check("rst_rv", 64'(l_rv), 64'd0);
    check("rst_addr", 64'(l_addr), 64'd0);
    check("rst_rdata", 64'(l_rdata), 64'd0);
    check("rst_out", 64'(l_out), 64'd0);
    check("rst_err", 64'(l_err), 64'd0);
    rst = 1'b1;
    idle();
    cyc();

    // single read
    req = 2'b01;
    addr[0 +: AW] = 32'h100;
    gnt = 1'b1;
    cyc();
    check("tp1_gnt", 64'(l_gnt), 64'h1);
    check("tp1_addr", 64'(l_addr), 64'h100);
    idle();
    cyc();
    rvalid = 1'b1;
    rdata = 32'hDEADBEEF;
    cyc();
    check("tp1_rv", 64'(l_rv), 64'h1);
    check("tp1_rdata", 64'(l_rdata), 64'hDEADBEEF);
    idle();
    cyc();
    check("tp1_out", 64'(l_out), 64'd0);

    // round-robin from a fresh reset
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    req = 2'b11;
    gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rvalid = (i > 0);
      cyc();
      g[i] = l_gnt;
      r[i] = l_rv;
    end
    idle();
    rvalid = 1'b1;
    cyc();
    r[4] = l_rv;
    rvalid = 1'b0;
    check("rr_g0", 64'(g[0]), 64'h1);
    check("rr_g1", 64'(g[1]), 64'h2);
    check("rr_g2", 64'(g[2]), 64'h1);
    check("rr_g3", 64'(g[3]), 64'h2);
    check("rr_r1", 64'(r[1]), 64'h1);
    check("rr_r2", 64'(r[2]), 64'h2);
    check("rr_r3", 64'(r[3]), 64'h1);
    check("rr_r4", 64'(r[4]), 64'h2);

    // back-pressure: point rr at ch1 first
    req = 2'b01;
    gnt = 1'b1;
    cyc();
    idle();
    rvalid = 1'b1;
    cyc();
    rvalid = 1'b0;
    req = 2'b11;
    addr = {32'h200, 32'h300};
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_addr", 64'(l_addr), 64'h200);
      check("bp_nogrant", 64'(l_gnt), 64'd0);
    end
    gnt = 1'b1;
    cyc();
    check("bp_gnt1", 64'(l_gnt), 64'h2);
    cyc();
    check("bp_gnt0", 64'(l_gnt), 64'h1);
    check("bp_addr0", 64'(l_addr), 64'h300);
    idle();
    rvalid = 1'b1;
    cyc();
    check("bp_rv1", 64'(l_rv), 64'h2);
    cyc();
    check("bp_rv0", 64'(l_rv), 64'h1);
    rvalid = 1'b0;

    // full stall
    req = 2'b01;
    addr[0 +: AW] = 32'h400;
    gnt = 1'b1;
    cyc();
    cyc();
    cyc();
    check("full_req", 64'(l_req), 64'd0);
    check("full_out", 64'(l_out), 64'd2);
    rvalid = 1'b1;
    cyc();
    check("full_nobypass", 64'(l_req), 64'd0);
    check("full_rv", 64'(l_rv), 64'h1);
    rvalid = 1'b0;
    cyc();
    check("full_rereq", 64'(l_req), 64'd1);
    check("full_regnt", 64'(l_gnt), 64'h1);
    idle();
    rvalid = 1'b1;
    cyc();
    cyc();
    rvalid = 1'b0;
    cyc();
    check("full_drain", 64'(l_out), 64'd0);

    // write with byte enables
    req = 2'b10;
    we = 2'b10;
    be[BW +: BW] = 4'b0011;
    wdata[DW +: DW] = 32'h0000ABCD;
    gnt = 1'b1;
    cyc();
    check("wr_we", 64'(l_we), 64'd1);
    check("wr_be", 64'(l_be), 64'h3);
    check("wr_wdata", 64'(l_wdata), 64'hABCD);
    check("wr_gnt", 64'(l_gnt), 64'h2);
    idle();
    rvalid = 1'b1;
    cyc();
    check("wr_rv", 64'(l_rv), 64'h2);

    // spurious response
    cyc();
    check("sp_rv", 64'(l_rv), 64'd0);
    rvalid = 1'b0;
    cyc();
    check("sp_err", 64'(l_err), 64'd1);

    // reset mid-transaction, then stale response
    req = 2'b01;
    gnt = 1'b1;
    cyc();
    rst = 1'b0;
    req = 2'b11;
    rvalid = 1'b1;
    cyc();
    check("mr_req", 64'(l_req), 64'd0);
    check("mr_gnt", 64'(l_gnt), 64'd0);
    check("mr_rv", 64'(l_rv), 64'd0);
    check("mr_rdata", 64'(l_rdata), 64'd0);
    check("mr_out", 64'(l_out), 64'd0);
    check("mr_err", 64'(l_err), 64'd0);
    rst = 1'b1;
    idle();
    rvalid = 1'b1;
    cyc();
    check("st_rv", 64'(l_rv), 64'd0);
    rvalid = 1'b0;
    cyc();
    check("st_err", 64'(l_err), 64'd1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      req = NCH'($urandom_range(0, 3));
      if (locked) req[lock_ch] = 1'b1;
      addr = {$urandom, $urandom};
      we = NCH'($urandom_range(0, 3));
      be = {8'($urandom)};
      wdata = {$urandom, $urandom};
      gnt = ($urandom_range(0, 2) != 0);
      rvalid = (q.size() > 0) ?
               ($urandom_range(0, 1) == 1) :
               ($urandom_range(0, 49) == 0);
      rdata = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
